// File: rtl/pipeline_controller.sv
// Hazard/forwarding controller: stalls, flushes, redirect and operand bypass for a 5-stage pipe.
// All stall/flush/bypass outputs are combinational (same cycle); memBusy freezes everything else.
module pipeline_controller #(
  parameter int MULDIV_TIMEOUT = 40,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      idRs1,
  input  logic [4:0]      idRs2,
  input  logic [4:0]      exRd,
  input  logic            exRegWrite,
  input  logic            exIsLoad,
  input  logic [XLEN-1:0] exResult,
  input  logic [4:0]      maRd,
  input  logic            maRegWrite,
  input  logic [XLEN-1:0] maResult,
  input  logic [4:0]      wbRd,
  input  logic            wbRegWrite,
  input  logic [XLEN-1:0] wbResult,
  input  logic [XLEN-1:0] rfRs1,
  input  logic [XLEN-1:0] rfRs2,
  input  logic            exBranchMiss,
  input  logic [XLEN-1:0] exBranchTarget,
  input  logic            muldivStart,
  input  logic            muldivDone,
  input  logic            memBusy,
  output logic [XLEN-1:0] irregPc,
  output logic            irregPcValid,
  output logic            fetchStall,
  output logic            decodeStall,
  output logic            executeStall,
  output logic            memoryAccessStall,
  output logic            fetchFlush,
  output logic            decodeFlush,
  output logic            executeFlush,
  output logic            memoryAccessFlush,
  output logic [XLEN-1:0] bypassedRs1,
  output logic [XLEN-1:0] bypassedRs2,
  output logic            mulDivClear
);

  localparam int CNT_W = $clog2(MULDIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MULDIV_TIMEOUT);

  typedef enum logic [1:0] {RUN, MULDIV_WAIT, MEM_WAIT} state_e;

  state_e           state_q, state_d, ret_q, ret_d, eff_state;
  logic [CNT_W-1:0] muldivCnt_q, muldivCnt_d;
  logic             init_q;
  logic             load_use, timeout_hit;
  logic             fs, ds, es, ms, ff, df, ef, mf, pcv, clr;

  // Once memBusy clears, MEM_WAIT behaves as the state it interrupted so no cycle is lost.
  assign eff_state   = (state_q == MEM_WAIT) ? ret_q : state_q;
  assign timeout_hit = (muldivCnt_q == TIMEOUT_C);
  assign load_use    = exIsLoad && exRegWrite && (exRd != 5'd0) &&
                       ((exRd == idRs1) || (exRd == idRs2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      muldivCnt_q <= '0;
      init_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      muldivCnt_q <= muldivCnt_d;
      init_q      <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    muldivCnt_d = muldivCnt_q;
    if (memBusy) begin
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
    end else begin
      case (eff_state)
        MULDIV_WAIT: begin
          if (muldivDone || timeout_hit) begin
            state_d     = RUN;
            muldivCnt_d = '0;
          end else begin
            state_d     = MULDIV_WAIT;
            muldivCnt_d = muldivCnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          if (!exBranchMiss && muldivStart) begin
            state_d     = MULDIV_WAIT;
            muldivCnt_d = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    fs  = 1'b0; ds = 1'b0; es = 1'b0; ms = 1'b0;
    ff  = 1'b0; df = 1'b0; ef = 1'b0; mf = 1'b0;
    pcv = 1'b0; clr = 1'b0;
    if (rst) begin
      if (memBusy) begin
        fs = 1'b1; ds = 1'b1; es = 1'b1; ms = 1'b1;
      end else begin
        if (exBranchMiss) begin
          pcv = 1'b1; ff = 1'b1; df = 1'b1;
        end
        case (eff_state)
          MULDIV_WAIT: begin
            if (!muldivDone && timeout_hit) begin
              clr = 1'b1; ef = 1'b1; mf = 1'b1;
            end else if (!muldivDone) begin
              fs = 1'b1; ds = 1'b1; es = 1'b1; mf = 1'b1;
            end
          end
          default: begin
            if (!exBranchMiss && !muldivStart && load_use) begin
              fs = 1'b1; ds = 1'b1; ef = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Flushes stay high through reset and until the first edge after release.
  assign fetchStall        = fs;
  assign decodeStall       = ds;
  assign executeStall      = es;
  assign memoryAccessStall = ms;
  assign fetchFlush        = ff | init_q;
  assign decodeFlush       = df | init_q;
  assign executeFlush      = ef | init_q;
  assign memoryAccessFlush = mf | init_q;
  assign irregPcValid      = pcv;
  assign irregPc           = pcv ? exBranchTarget : '0;
  assign mulDivClear       = clr;

  always_comb begin
    bypassedRs1 = rfRs1;
    if (idRs1 != 5'd0) begin
      if (exRegWrite && !exIsLoad && (exRd == idRs1)) bypassedRs1 = exResult;
      else if (maRegWrite && (maRd == idRs1))         bypassedRs1 = maResult;
      else if (wbRegWrite && (wbRd == idRs1))         bypassedRs1 = wbResult;
    end
  end

  always_comb begin
    bypassedRs2 = rfRs2;
    if (idRs2 != 5'd0) begin
      if (exRegWrite && !exIsLoad && (exRd == idRs2)) bypassedRs2 = exResult;
      else if (maRegWrite && (maRd == idRs2))         bypassedRs2 = maResult;
      else if (wbRegWrite && (wbRd == idRs2))         bypassedRs2 = wbResult;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with a cycle-level reference model checked every cycle.
module tb_pipeline_controller;

  localparam int T = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  idRs1, idRs2, exRd, maRd, wbRd;
  logic        exRegWrite, exIsLoad, maRegWrite, wbRegWrite;
  logic [31:0] exResult, maResult, wbResult, rfRs1, rfRs2, exBranchTarget;
  logic        exBranchMiss, muldivStart, muldivDone, memBusy;
  logic [31:0] irregPc, bypassedRs1, bypassedRs2;
  logic        irregPcValid, mulDivClear;
  logic        fetchStall, decodeStall, executeStall, memoryAccessStall;
  logic        fetchFlush, decodeFlush, executeFlush, memoryAccessFlush;

  int checks = 0;
  int errors = 0;

  pipeline_controller #(.MULDIV_TIMEOUT(T), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .idRs1(idRs1), .idRs2(idRs2),
    .exRd(exRd), .exRegWrite(exRegWrite), .exIsLoad(exIsLoad), .exResult(exResult),
    .maRd(maRd), .maRegWrite(maRegWrite), .maResult(maResult),
    .wbRd(wbRd), .wbRegWrite(wbRegWrite), .wbResult(wbResult),
    .rfRs1(rfRs1), .rfRs2(rfRs2),
    .exBranchMiss(exBranchMiss), .exBranchTarget(exBranchTarget),
    .muldivStart(muldivStart), .muldivDone(muldivDone), .memBusy(memBusy),
    .irregPc(irregPc), .irregPcValid(irregPcValid),
    .fetchStall(fetchStall), .decodeStall(decodeStall),
    .executeStall(executeStall), .memoryAccessStall(memoryAccessStall),
    .fetchFlush(fetchFlush), .decodeFlush(decodeFlush),
    .executeFlush(executeFlush), .memoryAccessFlush(memoryAccessFlush),
    .bypassedRs1(bypassedRs1), .bypassedRs2(bypassedRs2),
    .mulDivClear(mulDivClear)
  );

  always #5 clk = ~clk;

  wire [7:0] vec = {fetchStall, decodeStall, executeStall, memoryAccessStall,
                    fetchFlush, decodeFlush, executeFlush, memoryAccessFlush};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operand source by the forwarding rules: x0 never forwarded, EX (non-load) > MA > WB > RF.
  function automatic logic [31:0] ref_byp(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (exRegWrite && !exIsLoad && exRd == rs) return exResult;
    if (maRegWrite && maRd == rs) return maResult;
    if (wbRegWrite && wbRd == rs) return wbResult;
    return rf;
  endfunction

  // Reference model: in_md = a multiply/divide is outstanding, waited = non-memBusy cycles spent on it.
  bit in_md = 0;
  int waited = 0;
  bit fresh = 1;

  always @(negedge clk) begin
    logic [7:0]  e_vec;
    logic        e_clr, e_pcv;
    logic [31:0] e_pc;
    bit          lu;
    e_vec = 8'h00; e_clr = 1'b0; e_pcv = 1'b0; e_pc = 32'h0;
    if (!rst) begin
      e_vec = 8'h0F;
      in_md = 0; waited = 0; fresh = 1;
    end else begin
      lu = exIsLoad && exRegWrite && exRd != 0 && (exRd == idRs1 || exRd == idRs2);
      if (memBusy) begin
        e_vec = 8'hF0;
      end else begin
        if (exBranchMiss) begin
          e_pcv = 1'b1; e_pc = exBranchTarget; e_vec[3] = 1'b1; e_vec[2] = 1'b1;
        end
        if (in_md) begin
          if (muldivDone) begin
            in_md = 0;
          end else if (waited == T) begin
            e_clr = 1'b1; e_vec[1] = 1'b1; e_vec[0] = 1'b1; in_md = 0;
          end else begin
            e_vec[7] = 1'b1; e_vec[6] = 1'b1; e_vec[5] = 1'b1; e_vec[0] = 1'b1;
            waited++;
          end
        end else if (!exBranchMiss && muldivStart) begin
          in_md = 1; waited = 0;
        end else if (!exBranchMiss && lu) begin
          e_vec[7] = 1'b1; e_vec[6] = 1'b1; e_vec[1] = 1'b1;
        end
      end
      if (fresh) e_vec[3:0] = 4'hF;
      fresh = 0;
    end
    chk("m_stall_flush", {24'h0, vec}, {24'h0, e_vec});
    chk("m_clear", {31'h0, mulDivClear}, {31'h0, e_clr});
    chk("m_pc_valid", {31'h0, irregPcValid}, {31'h0, e_pcv});
    chk("m_pc", irregPc, e_pc);
    chk("m_byp1", bypassedRs1, ref_byp(idRs1, rfRs1));
    chk("m_byp2", bypassedRs2, ref_byp(idRs2, rfRs2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idRs1 = 0; idRs2 = 0; exRd = 0; maRd = 0; wbRd = 0;
    exRegWrite = 0; exIsLoad = 0; maRegWrite = 0; wbRegWrite = 0;
    exResult = 0; maResult = 0; wbResult = 0; rfRs1 = 0; rfRs2 = 0;
    exBranchMiss = 0; exBranchTarget = 0; muldivStart = 0; muldivDone = 0; memBusy = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int stalled, first, nclr;
    clear_inputs();
    rst = 0;
    memBusy = 1;
    @(negedge clk);
    chk("reset_vec", {24'h0, vec}, 32'h0F);
    chk("reset_clear", {31'h0, mulDivClear}, 32'h0);
    step();
    memBusy = 0;
    step();
    rst = 1;
    @(negedge clk);
    chk("flush_hold_after_release", {24'h0, vec}, 32'h0F);
    step();
    @(negedge clk);
    chk("idle_vec", {24'h0, vec}, 32'h00);

    // load-use on rs2
    step();
    exRd = 5; exIsLoad = 1; exRegWrite = 1; idRs2 = 5; exResult = 32'h1111; rfRs2 = 32'h2222;
    @(negedge clk);
    chk("loaduse_vec", {24'h0, vec}, 32'hC2);
    chk("loaduse_byp2", bypassedRs2, 32'h2222);
    step();
    exIsLoad = 0; exRegWrite = 0;
    @(negedge clk);
    chk("loaduse_gone", {24'h0, vec}, 32'h00);

    // branch mispredict, then coincident with load-use
    step();
    exBranchMiss = 1; exBranchTarget = 32'h400;
    @(negedge clk);
    chk("branch_pc", irregPc, 32'h400);
    chk("branch_valid", {31'h0, irregPcValid}, 32'h1);
    chk("branch_vec", {24'h0, vec}, 32'h0C);
    step();
    exIsLoad = 1; exRegWrite = 1;
    @(negedge clk);
    chk("branch_over_loaduse", {24'h0, vec}, 32'h0C);
    step();
    clear_inputs();
    @(negedge clk);
    chk("no_redirect_pc", irregPc, 32'h0);

    // forwarding
    step();
    idRs1 = 0; exRd = 0; exRegWrite = 1; exResult = 32'hDEADBEEF; rfRs1 = 32'h12345678;
    @(negedge clk);
    chk("x0_not_bypassed", bypassedRs1, 32'h12345678);
    step();
    idRs1 = 7; exRd = 3; maRd = 7; maRegWrite = 1; wbRd = 7; wbRegWrite = 1;
    maResult = 32'hAAAA0001; wbResult = 32'hBBBB0002; idRs2 = 3; rfRs2 = 32'h55;
    @(negedge clk);
    chk("ma_over_wb", bypassedRs1, 32'hAAAA0001);
    chk("ex_bypass", bypassedRs2, 32'hDEADBEEF);
    step();
    maRegWrite = 0;
    @(negedge clk);
    chk("wb_bypass", bypassedRs1, 32'hBBBB0002);
    step();
    clear_inputs();

    // multiply/divide completing after 10 stalled cycles
    muldivStart = 1;
    @(negedge clk);
    chk("start_no_stall", {24'h0, vec}, 32'h00);
    step();
    muldivStart = 0;
    stalled = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (vec == 8'hE1) stalled++;
      step();
    end
    chk("muldiv_stall_cycles", stalled, 10);
    muldivDone = 1;
    @(negedge clk);
    chk("done_drops_stall", {24'h0, vec}, 32'h00);
    chk("done_no_clear", {31'h0, mulDivClear}, 32'h0);
    step();
    muldivDone = 0;
    @(negedge clk);
    chk("back_in_run", {24'h0, vec}, 32'h00);
    step();

    // timeout without memBusy, then with 3 memBusy cycles in the middle
    for (int pass = 0; pass < 2; pass++) begin
      muldivStart = 1;
      step();
      muldivStart = 0;
      first = -1; nclr = 0;
      for (int k = 0; k < 70; k++) begin
        memBusy = (pass == 1) && (k >= 5) && (k <= 7);
        @(negedge clk);
        if (memBusy) chk("membusy_all_stall", {24'h0, vec}, 32'hF0);
        if (mulDivClear) begin
          nclr++;
          if (first < 0) first = k;
        end
        step();
      end
      memBusy = 0;
      chk(pass == 0 ? "timeout_cycle" : "timeout_cycle_membusy", first, (pass == 0) ? T : T + 3);
      chk("clear_pulse_count", nclr, 1);
    end

    // reset in the middle of a multiply/divide wait
    muldivStart = 1;
    step();
    muldivStart = 0;
    repeat (5) step();
    rst = 0;
    @(negedge clk);
    chk("midwait_reset_vec", {24'h0, vec}, 32'h0F);
    step();
    rst = 1;
    @(negedge clk);
    chk("midwait_release_flush", {24'h0, vec}, 32'h0F);
    step();
    @(negedge clk);
    chk("midwait_run", {24'h0, vec}, 32'h00);
    nclr = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      @(negedge clk);
      if (mulDivClear) nclr++;
    end
    chk("midwait_no_clear", nclr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MULDIV_TIMEOUT, default 40, the maximum cycles spent waiting for muldivDone before the multiply/divide unit is aborted.
REQ-002 The block SHALL have parameter XLEN, default 32, the width of data and PC values.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst, input, 1, the reset, asynchronous and active-low.
REQ-005 The block SHALL have inputs idRs1, idRs2, 5 bits each, the decode-stage source registers.
REQ-006 The block SHALL have inputs exRd, 5; exRegWrite, 1; exIsLoad, 1; exResult, XLEN, describing the execute-stage instruction.
REQ-007 The block SHALL have inputs maRd, 5; maRegWrite, 1; maResult, XLEN, describing the memory-access-stage instruction.
REQ-008 The block SHALL have inputs wbRd, 5; wbRegWrite, 1; wbResult, XLEN, describing the writeback-stage instruction.
REQ-009 The block SHALL have inputs rfRs1, rfRs2, XLEN each, the register-file read data.
REQ-010 The block SHALL have inputs exBranchMiss, 1, and exBranchTarget, XLEN, the mispredict flag and the corrected PC.
REQ-011 The block SHALL have inputs muldivStart, 1, and muldivDone, 1, the multiply/divide handshake.
REQ-012 The block SHALL have input memBusy, 1, set while data memory is not ready.
REQ-013 The block SHALL have outputs irregPc, XLEN, and irregPcValid, 1, the fetch redirect.
REQ-014 The block SHALL have outputs {fetch,decode,execute,memoryAccess}Stall and {fetch,decode,execute,memoryAccess}Flush, 1 bit each.
REQ-015 The block SHALL have outputs bypassedRs1 and bypassedRs2, XLEN each, and mulDivClear, 1.

Function
REQ-016 The FSM SHALL have states RUN, MULDIV_WAIT and MEM_WAIT, plus a counter muldivCnt of clog2(MULDIV_TIMEOUT+1) bits.
REQ-017 Event priority, highest first, SHALL be: memBusy, exBranchMiss, muldiv, load-use.
REQ-018 memBusy=1 in any state SHALL:
- assert all four Stall outputs combinationally in the same cycle;
- set state MEM_WAIT;
- freeze muldivCnt.
REQ-019 In MEM_WAIT, memBusy=0 SHALL return the FSM to the state held before MEM_WAIT; the stalls SHALL drop in that same cycle.
REQ-020 exBranchMiss=1 with memBusy=0 SHALL, combinationally:
- set irregPcValid=1 and irregPc=exBranchTarget;
- assert fetchFlush and decodeFlush.
REQ-021 irregPcValid=0 SHALL force irregPc=0.
REQ-022 muldivStart=1 in RUN SHALL enter MULDIV_WAIT next cycle with muldivCnt=0.
REQ-023 In MULDIV_WAIT, the block SHALL:
- assert fetchStall, decodeStall and executeStall;
- assert memoryAccessFlush (bubble);
- increment muldivCnt each cycle.
REQ-024 muldivDone=1 in MULDIV_WAIT SHALL drop all stalls that cycle and return the FSM to RUN.
REQ-025 If muldivCnt reaches MULDIV_TIMEOUT without muldivDone, the block SHALL pulse mulDivClear and executeFlush for exactly one cycle and return to RUN.
REQ-026 A load-use hazard SHALL be: exIsLoad=1, exRegWrite=1, exRd!=0, and exRd equal to idRs1 or idRs2.
REQ-027 On a load-use hazard in RUN, the block SHALL assert fetchStall, decodeStall and executeFlush for that cycle only, with no state change.
REQ-028 exBranchMiss coincident with load-use SHALL produce flush only; the load-use stall SHALL be suppressed.
REQ-029 bypassedRs1 SHALL be selected in this priority order:
- exResult if exRegWrite=1, exIsLoad=0, exRd=idRs1 and idRs1!=0;
- else maResult on an MA match;
- else wbResult on a WB match;
- else rfRs1.
REQ-030 bypassedRs2 SHALL be selected the same way using idRs2.
REQ-031 Register x0 SHALL never be bypassed; idRs=0 SHALL always yield rfRs.
REQ-032 Every Stall/Flush output SHALL be 0 when no event is active.

Reset
REQ-033 rst=0 SHALL, asynchronously:
- set state RUN and muldivCnt=0;
- set irregPcValid=0, irregPc=0 and mulDivClear=0;
- set all Stall outputs to 0;
- set all Flush outputs to 1.
REQ-034 Reset asserted mid-MULDIV_WAIT SHALL abandon the wait; after release the FSM SHALL be in RUN with mulDivClear=0.
REQ-035 After rst rises, the Flush outputs SHALL fall to 0 on the first clock edge.

Verification
REQ-036 exRd=5, exIsLoad=1, exRegWrite=1, idRs2=5 -> fetchStall=decodeStall=executeFlush=1 for one cycle; bypassedRs2 not taken from exResult.
REQ-037 exBranchMiss=1, exBranchTarget=0x00000400 -> irregPcValid=1, irregPc=0x400, fetchFlush=decodeFlush=1 in the same cycle.
REQ-038 muldivStart pulse, then muldivDone asserted 10 cycles later -> stalls held for 10 cycles, no mulDivClear, FSM back in RUN.
REQ-039 muldivStart with muldivDone never asserted -> mulDivClear=1 for exactly one cycle, MULDIV_TIMEOUT cycles after entering MULDIV_WAIT.
REQ-040 memBusy raised for 3 cycles during MULDIV_WAIT -> all stalls asserted and muldivCnt frozen; timeout is reached 3 cycles later than without memBusy.
REQ-041 idRs1=0 with exRd=0, exRegWrite=1, exResult=0xDEADBEEF -> bypassedRs1=rfRs1; idRs1=7 with maRd=wbRd=7 -> maResult selected.
